// File: rtl/gat_pkg.sv
// Shared GAT definitions: width helpers, argmax reader FSM state type and
// the per-node classification record for the default network size.
// Optional build macro GAT_ARGMAX_MAXVAL_EN adds the winning score to the record.
package gat_pkg;

  // $clog2 that never returns 0, so a degenerate size still yields a 1-bit field.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int class_w(input int num_feature_final);
    return clog2_min1(num_feature_final);
  endfunction

  function automatic int node_w(input int num_subgraphs);
    return clog2_min1(num_subgraphs);
  endfunction

  function automatic int feat_addr_w(input int num_subgraphs, input int num_feature_final);
    return clog2_min1(num_subgraphs * num_feature_final);
  endfunction

  // Default network size.
  localparam int GAT_NUM_SUBGRAPHS     = 25;
  localparam int GAT_NUM_FEATURE_FINAL = 7;
  localparam int GAT_DATA_WIDTH        = 8;
  localparam int GAT_CLASS_W           = class_w(GAT_NUM_FEATURE_FINAL);
  localparam int GAT_NODE_W            = node_w(GAT_NUM_SUBGRAPHS);
  localparam int GAT_FEAT_ADDR_W       = feat_addr_w(GAT_NUM_SUBGRAPHS, GAT_NUM_FEATURE_FINAL);

  typedef enum logic [2:0] {
    ARG_IDLE  = 3'd0,
    ARG_READ  = 3'd1,
    ARG_DRAIN = 3'd2,
    ARG_OUT   = 3'd3,
    ARG_DONE  = 3'd4
  } argmax_state_e;

  // Host-side view of one classified node in the default configuration.
  typedef struct packed {
    logic [GAT_NODE_W-1:0]            node;
    logic [GAT_CLASS_W-1:0]           idx;
`ifdef GAT_ARGMAX_MAXVAL_EN
    logic signed [GAT_DATA_WIDTH-1:0] max_val;
`endif
  } cls_result_t;

endpackage

// File: rtl/gat_argmax_cmp.sv
// Streaming signed max/index tracker. first_i restarts the search with the
// current sample; later samples replace the running max only when strictly
// greater, so ties keep the earliest index. Also usable for softmax max-finding.
module gat_argmax_cmp #(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         vld_i,
  input  logic                         first_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic        [IDX_W-1:0]      idx_i,
  output logic signed [DATA_WIDTH-1:0] max_o,
  output logic        [IDX_W-1:0]      idx_o
);

  logic signed [DATA_WIDTH-1:0] max_q;
  logic        [IDX_W-1:0]      idx_q;

  // Running max/index update on each valid sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      idx_q <= '0;
    end else if (vld_i && (first_i || (data_i > max_q))) begin
      // NOTE: non-blocking assignments keep every register in this block
      // sampling pre-edge values, independent of statement order.
      max_q <= data_i;
      idx_q <= idx_i;
    end
  end

  assign max_o = max_q;
  assign idx_o = idx_q;

endmodule

// File: rtl/gat_argmax_reader.sv
// Walks the final-layer feature BRAM node by node after conv2 completes and
// streams the argmax class of each node on a valid/ready interface.
// Optional build macro GAT_ARGMAX_MAXVAL_EN adds cls_max_o (winning score).
module gat_argmax_reader
  import gat_pkg::*;
#(
  parameter int  NUM_SUBGRAPHS     = 25,
  parameter int  NUM_FEATURE_FINAL = 7,
  parameter int  DATA_WIDTH        = 8,
  parameter int  BRAM_RD_LAT       = 2,
  localparam int FEAT_ADDR_W       = feat_addr_w(NUM_SUBGRAPHS, NUM_FEATURE_FINAL),
  localparam int CLASS_W           = class_w(NUM_FEATURE_FINAL),
  localparam int NODE_W            = node_w(NUM_SUBGRAPHS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  output logic [FEAT_ADDR_W-1:0] feat_bram_addrb,
  input  logic [DATA_WIDTH-1:0]  feat_bram_dout,
  output logic                   cls_vld_o,
  input  logic                   cls_rdy_i,
  output logic [CLASS_W-1:0]     cls_idx_o,
  output logic [NODE_W-1:0]      cls_node_o,
`ifdef GAT_ARGMAX_MAXVAL_EN
  output logic [DATA_WIDTH-1:0]  cls_max_o,
`endif
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int                     DRAIN_W     = $clog2(BRAM_RD_LAT + 1);
  localparam logic [CLASS_W-1:0]     LAST_FEAT   = CLASS_W'(NUM_FEATURE_FINAL - 1);
  localparam logic [NODE_W-1:0]      LAST_NODE   = NODE_W'(NUM_SUBGRAPHS - 1);
  localparam logic [FEAT_ADDR_W-1:0] NODE_STRIDE = FEAT_ADDR_W'(NUM_FEATURE_FINAL);
  // DRAIN lasts BRAM_RD_LAT+1 cycles: latency of the last read plus its compare.
  localparam logic [DRAIN_W-1:0]     DRAIN_LAST  = DRAIN_W'(BRAM_RD_LAT);

  argmax_state_e          state_q;
  logic [CLASS_W-1:0]     feat_q;
  logic [NODE_W-1:0]      node_q;
  logic [FEAT_ADDR_W-1:0] node_base_q;
  logic [FEAT_ADDR_W-1:0] addr_q;
  logic [DRAIN_W-1:0]     drain_q;
  logic                   done_q;
  logic                   vld_q;
  logic [CLASS_W-1:0]     out_idx_q;
  logic [NODE_W-1:0]      out_node_q;
`ifdef GAT_ARGMAX_MAXVAL_EN
  logic [DATA_WIDTH-1:0]  out_max_q;
`endif

  // Read-tag pipeline: travels alongside the BRAM read so each returning
  // sample arrives with its feature index.
  logic                   tag_vld_q [BRAM_RD_LAT];
  logic [CLASS_W-1:0]     tag_idx_q [BRAM_RD_LAT];

  logic signed [DATA_WIDTH-1:0] cmp_max;
  logic [CLASS_W-1:0]           cmp_idx;

  // Frame FSM, address generation and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARG_IDLE;
      feat_q      <= '0;
      node_q      <= '0;
      node_base_q <= '0;
      addr_q      <= '0;
      drain_q     <= '0;
      done_q      <= 1'b0;
      vld_q       <= 1'b0;
      out_idx_q   <= '0;
      out_node_q  <= '0;
`ifdef GAT_ARGMAX_MAXVAL_EN
      out_max_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ARG_IDLE: begin
          if (start_i) begin
            state_q     <= ARG_READ;
            feat_q      <= '0;
            node_q      <= '0;
            node_base_q <= '0;
            addr_q      <= '0;
            drain_q     <= '0;
          end
        end
        ARG_READ: begin
          if (feat_q == LAST_FEAT) begin
            state_q <= ARG_DRAIN;
            drain_q <= '0;
          end else begin
            feat_q <= feat_q + 1'b1;
            addr_q <= addr_q + 1'b1;
          end
        end
        ARG_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_q    <= ARG_OUT;
            vld_q      <= 1'b1;
            out_idx_q  <= cmp_idx;
            out_node_q <= node_q;
`ifdef GAT_ARGMAX_MAXVAL_EN
            out_max_q  <= cmp_max;
`endif
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        ARG_OUT: begin
          // vld_q is always set here, so ready alone completes the handshake.
          if (cls_rdy_i) begin
            vld_q <= 1'b0;
            if (node_q == LAST_NODE) begin
              state_q <= ARG_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= ARG_READ;
              node_q      <= node_q + 1'b1;
              feat_q      <= '0;
              node_base_q <= node_base_q + NODE_STRIDE;
              addr_q      <= node_base_q + NODE_STRIDE;
            end
          end
        end
        ARG_DONE: state_q <= ARG_IDLE;
        default:  state_q <= ARG_IDLE;
      endcase
    end
  end

  // Tag shift register aligned with the BRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this small array is reset on purpose; a stale valid tag after
      // reset would inject a phantom sample into the compare.
      for (int i = 0; i < BRAM_RD_LAT; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_idx_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0] <= (state_q == ARG_READ);
      tag_idx_q[0] <= feat_q;
      for (int i = 1; i < BRAM_RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

  gat_argmax_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (CLASS_W)
  ) u_cmp (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_i   (tag_vld_q[BRAM_RD_LAT-1]),
    .first_i (tag_idx_q[BRAM_RD_LAT-1] == '0),
    .data_i  (feat_bram_dout),
    .idx_i   (tag_idx_q[BRAM_RD_LAT-1]),
    .max_o   (cmp_max),
    .idx_o   (cmp_idx)
  );

`ifdef GAT_ARGMAX_MAXVAL_EN
  assign cls_max_o = out_max_q;
`else
  // The running max is still needed inside the tracker; it just has no port.
  logic unused_cmp_max;
  assign unused_cmp_max = ^cmp_max;
`endif

  assign feat_bram_addrb = addr_q;
  assign cls_vld_o       = vld_q;
  assign cls_idx_o       = out_idx_q;
  assign cls_node_o      = out_node_q;
  assign busy_o          = (state_q != ARG_IDLE);
  assign done_o          = done_q;

endmodule

// File: tb/tb_gat_argmax_reader.sv
// Self-checking bench for gat_argmax_reader (4 nodes x 7 classes, read
// latency 2). Expected results are queued when a frame is started and popped
// on each output handshake. Define GAT_ARGMAX_MAXVAL_EN to also check cls_max_o.
module tb_gat_argmax_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic [4:0] feat_bram_addrb;
  logic [7:0] feat_bram_dout;
  logic       cls_vld_o;
  logic       cls_rdy_i;
  logic [2:0] cls_idx_o;
  logic [1:0] cls_node_o;
`ifdef GAT_ARGMAX_MAXVAL_EN
  logic [7:0] cls_max_o;
`endif
  logic       busy_o;
  logic       done_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int node;
    int idx;
    int maxv;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] mem [32];
  logic [7:0] rd1, rd2;

  int basic_rows [4][7] = '{'{0, 1, 2, 3, 4, 5, 6},
                            '{9, -3, 0, 0, 0, 0, 0},
                            '{-5, -5, -1, -7, -2, -9, -8},
                            '{3, 3, 3, 3, 3, 3, 3}};
  int edge_rows  [4][7] = '{'{-128, -128, 127, 127, -128, 0, 0},
                            '{-128, -128, -128, -128, -128, -128, -128},
                            '{-7, -6, -5, -4, -3, -2, -128},
                            '{-1, -1, -1, -1, -1, -1, 0}};

  always #5 clk = ~clk;

  // Two-cycle read-latency BRAM model.
  always @(posedge clk) begin
    rd1 <= mem[feat_bram_addrb];
    rd2 <= rd1;
  end
  assign feat_bram_dout = rd2;

  gat_argmax_reader #(
    .NUM_SUBGRAPHS     (4),
    .NUM_FEATURE_FINAL (7),
    .DATA_WIDTH        (8),
    .BRAM_RD_LAT       (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .feat_bram_addrb (feat_bram_addrb),
    .feat_bram_dout  (feat_bram_dout),
    .cls_vld_o       (cls_vld_o),
    .cls_rdy_i       (cls_rdy_i),
    .cls_idx_o       (cls_idx_o),
    .cls_node_o      (cls_node_o),
`ifdef GAT_ARGMAX_MAXVAL_EN
    .cls_max_o       (cls_max_o),
`endif
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  task automatic load_rows(input int rows [4][7]);
    for (int a = 0; a < 32; a++) mem[a] = 8'd0;
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 7; i++) mem[n*7 + i] = 8'(rows[n][i]);
  endtask

  task automatic push_exp(input int node, input int idx, input int maxv);
    exp_t e;
    e.node = node;
    e.idx  = idx;
    e.maxv = maxv;
    exp_q.push_back(e);
  endtask

  task automatic push_basic_exp();
    push_exp(0, 6, 6);
    push_exp(1, 0, 9);
    push_exp(2, 2, -1);
    push_exp(3, 0, 3);
  endtask

  // Called and returns at #1 after a rising edge.
  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Runs until done_o plus a quiet tail; pops the scoreboard on handshakes,
  // optionally stalls ready on one node and pulses start_i at one address.
  task automatic collect(input int stall_node, input int stall_len,
                         input int pulse_addr, input int exp_results);
    int   done_cnt   = 0;
    int   got        = 0;
    int   stall_left = stall_len;
    int   tail       = -1;
    int   last_hs    = 0;
    bit   pulsed     = 1'b0;
    bit   stalling;
    exp_t e;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      start_i = 1'b0;
      if (pulse_addr >= 0 && !pulsed && int'(feat_bram_addrb) == pulse_addr && busy_o) begin
        start_i = 1'b1;
        pulsed  = 1'b1;
      end
      stalling  = (stall_left > 0) && cls_vld_o && (int'(cls_node_o) == stall_node);
      cls_rdy_i = !stalling;
      @(negedge clk);
      if (stalling) begin
        stall_left--;
        checks++;
        if (cls_vld_o !== 1'b1 || exp_q.size() == 0 || int'(cls_idx_o) != exp_q[0].idx ||
            int'(feat_bram_addrb) != stall_node*7 + 6) begin
          errors++;
          $display("FAIL stall_hold cyc %0d: vld=%b idx=%0d addr=%0d, required vld=1 idx=%0d addr=%0d",
                   cyc, cls_vld_o, cls_idx_o, feat_bram_addrb,
                   (exp_q.size() > 0) ? exp_q[0].idx : -1, stall_node*7 + 6);
        end
      end else if (cls_vld_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: node=%0d idx=%0d, required no result", cls_node_o, cls_idx_o);
        end else begin
          e = exp_q.pop_front();
          if (int'(cls_node_o) != e.node || int'(cls_idx_o) != e.idx) begin
            errors++;
            $display("FAIL result %0d: node/idx=%0d/%0d, required %0d/%0d",
                     got, cls_node_o, cls_idx_o, e.node, e.idx);
          end
`ifdef GAT_ARGMAX_MAXVAL_EN
          checks++;
          if (int'($signed(cls_max_o)) != e.maxv) begin
            errors++;
            $display("FAIL max %0d: cls_max_o=%0d, required %0d", got, $signed(cls_max_o), e.maxv);
          end
`endif
        end
        if (stall_len == 0 && got > 0) begin
          checks++;
          if (cyc - last_hs != 11) begin
            errors++;
            $display("FAIL node_period: %0d cycles, required 11", cyc - last_hs);
          end
        end
        last_hs = cyc;
        got++;
      end
      if (done_o === 1'b1) done_cnt++;
      if (done_cnt > 0 && tail < 0) tail = 12;
      if (tail > 0) tail--;
      if (tail == 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start_i   = 1'b0;
    cls_rdy_i = 1'b1;
    checks++;
    if (tail != 0) begin
      errors++;
      $display("FAIL frame_timeout: done_o never seen, required one pulse");
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL done_count: %0d pulses, required 1", done_cnt);
    end
    checks++;
    if (got != exp_results || exp_q.size() != 0) begin
      errors++;
      $display("FAIL result_count: got %0d (left %0d), required %0d (left 0)", got, exp_q.size(), exp_results);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_done: busy_o=%b, required 0", busy_o);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (cls_vld_o !== 1'b0 || cls_idx_o !== 3'd0 || cls_node_o !== 2'd0 ||
        busy_o !== 1'b0 || done_o !== 1'b0 || feat_bram_addrb !== 5'd0) begin
      errors++;
      $display("FAIL %s: vld=%b idx=%0d node=%0d busy=%b done=%b addr=%0d, required all 0",
               tag, cls_vld_o, cls_idx_o, cls_node_o, busy_o, done_o, feat_bram_addrb);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    start_i   = 1'b0;
    cls_rdy_i = 1'b0;
    load_rows(basic_rows);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_state");
`ifdef GAT_ARGMAX_MAXVAL_EN
    checks++;
    if (cls_max_o !== 8'd0) begin
      errors++;
      $display("FAIL reset_max: cls_max_o=%0d, required 0", cls_max_o);
    end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("idle_after_reset");
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int n = 0;
    load_rows(basic_rows);
    push_basic_exp();
    cls_rdy_i = 1'b1;
    start_i   = 1'b1;
    do begin
      @(posedge clk); #1;
      start_i = 1'b0;
      n++;
    end while (cls_vld_o !== 1'b1 && n < 50);
    checks++;
    if (n != 11) begin
      errors++;
      $display("FAIL first_valid_latency: %0d cycles, required 11", n);
    end
    collect(-1, 0, -1, 4);
  endtask

  task automatic test_backpressure();
    load_rows(basic_rows);
    push_basic_exp();
    cls_rdy_i = 1'b1;
    pulse_start();
    collect(1, 20, -1, 4);
  endtask

  task automatic test_boundary();
    load_rows(edge_rows);
    push_exp(0, 2, 127);
    push_exp(1, 0, -128);
    push_exp(2, 5, -2);
    push_exp(3, 6, 0);
    cls_rdy_i = 1'b1;
    pulse_start();
    collect(-1, 0, -1, 4);
  endtask

  task automatic test_ignored_start();
    load_rows(basic_rows);
    push_basic_exp();
    cls_rdy_i = 1'b1;
    pulse_start();
    // Address 16 is feature 2 of node 2, only ever presented during READ.
    collect(-1, 0, 16, 4);
  endtask

  task automatic test_reset_midframe();
    int n         = 0;
    bit seen_done = 1'b0;
    load_rows(basic_rows);
    exp_q.delete();
    cls_rdy_i = 1'b1;
    pulse_start();
    while (int'(feat_bram_addrb) != 13 && n < 200) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) seen_done = 1'b1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL reach_node1_drain: addr=%0d, required 13", feat_bram_addrb);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_idle_outputs("midframe_reset");
      if (done_o === 1'b1) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done_o === 1'b1) seen_done = 1'b1;
      check_idle_outputs("no_restart_without_start");
      @(posedge clk); #1;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL midframe_done: done_o pulsed, required none");
    end
    push_basic_exp();
    pulse_start();
    collect(-1, 0, -1, 4);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_boundary();
    test_ignored_start();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
